// File: rtl/cpu_bus_bridge.sv
`default_nettype none
// ============================================================================
// Module      : cpu_bus_bridge
// Description : Bridges the 6502 core bus into the PSRAM controller request
//               interface in the clkSys domain.
//               - Serves the VIC colour registers $D020/$D021 locally.
//               - Answers the rest of $Dxxx with open bus.
//               - Turns every other access into one memory transaction.
//               - Flags timeouts and overruns with sticky bits.
//               Optional macro GM64_RST_VEC_OVERRIDE_EN serves reads of
//               $FFFC/$FFFD locally from RST_VEC_LO/RST_VEC_HI.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_bus_bridge #(
    parameter logic [23:0] MEM_BASE       = 24'h000000,
    parameter int          TIMEOUT_CYCLES = 64,
    parameter logic [7:0]  RST_VEC_LO     = 8'h00,
    parameter logic [7:0]  RST_VEC_HI     = 8'h03
) (
    input  logic        clkSys,
    input  logic        reset,
    input  logic        i_phi0,
    input  logic [15:0] i_addr,
    input  logic [7:0]  i_cpu_wdata,
    input  logic        i_we,
    output logic [7:0]  o_cpu_rdata,
    output logic        o_mem_cs,
    output logic        o_mem_write,
    output logic [23:0] o_mem_addr,
    output logic [7:0]  o_mem_wdata,
    input  logic [7:0]  i_mem_rdata,
    input  logic        i_mem_busy,
    input  logic        i_mem_data_ready,
    output logic [3:0]  o_border_col,
    output logic [3:0]  o_bg_col,
    output logic        o_timeout,
    output logic        o_overrun
);

    // Counter wide enough to hold TIMEOUT_CYCLES-1.
    localparam int c_CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_phi0_q;
    logic [15:0]         r_addr;
    logic                r_we;
    logic [7:0]          r_wdata;
    logic [c_CNT_W-1:0]  r_cnt;
    logic                r_busy_seen;

    logic w_phi0_rise;
    logic w_is_border;
    logic w_is_bg;
    logic w_is_io;
    logic w_cnt_last;

    // Bus cycle start and address decode on the live bus (used in the capture cycle).
    assign w_phi0_rise = i_phi0 & ~r_phi0_q;
    assign w_is_border = (i_addr == 16'hD020);
    assign w_is_bg     = (i_addr == 16'hD021);
    assign w_is_io     = (i_addr[15:12] == 4'hD);
    assign w_cnt_last  = (r_cnt == c_CNT_LAST);

`ifdef GM64_RST_VEC_OVERRIDE_EN
    logic w_is_vec_lo;
    logic w_is_vec_hi;

    // Reset-vector reads are answered locally; writes still go to memory.
    assign w_is_vec_lo = (i_addr == 16'hFFFC) & ~i_we;
    assign w_is_vec_hi = (i_addr == 16'hFFFD) & ~i_we;
`else
    logic w_unused_rst_vec;

    // Vector parameters have no function without the override.
    assign w_unused_rst_vec = ^{RST_VEC_LO, RST_VEC_HI};
`endif

    // Bridge FSM: capture, local decode, memory request, completion and timeout.
    always_ff @(posedge clkSys) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_phi0_q     <= 1'b0;
            r_addr       <= 16'h0000;
            r_we         <= 1'b0;
            r_wdata      <= 8'h00;
            r_cnt        <= '0;
            r_busy_seen  <= 1'b0;
            o_cpu_rdata  <= 8'hFF;
            o_mem_cs     <= 1'b0;
            o_mem_write  <= 1'b0;
            o_mem_addr   <= 24'h000000;
            o_mem_wdata  <= 8'h00;
            o_border_col <= 4'h0;
            o_bg_col     <= 4'h0;
            o_timeout    <= 1'b0;
            o_overrun    <= 1'b0;
        end else begin
            r_phi0_q <= i_phi0;
            o_mem_cs <= 1'b0;

            // A new bus cycle while busy is dropped and only flagged.
            if (w_phi0_rise && (r_state != S_IDLE)) begin
                o_overrun <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_phi0_rise) begin
                        r_addr  <= i_addr;
                        r_we    <= i_we;
                        r_wdata <= i_cpu_wdata;
                        if (w_is_border) begin
                            if (i_we) o_border_col <= i_cpu_wdata[3:0];
                            else      o_cpu_rdata  <= {4'hF, o_border_col};
                        end else if (w_is_bg) begin
                            if (i_we) o_bg_col    <= i_cpu_wdata[3:0];
                            else      o_cpu_rdata <= {4'hF, o_bg_col};
                        end else if (w_is_io) begin
                            if (!i_we) o_cpu_rdata <= 8'hFF;
`ifdef GM64_RST_VEC_OVERRIDE_EN
                        end else if (w_is_vec_lo) begin
                            o_cpu_rdata <= RST_VEC_LO;
                        end else if (w_is_vec_hi) begin
                            o_cpu_rdata <= RST_VEC_HI;
`endif
                        end else begin
                            r_cnt   <= '0;
                            r_state <= S_ISSUE;
                        end
                    end
                end

                S_ISSUE: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_cnt_last) begin
                        o_timeout <= 1'b1;
                        if (!r_we) o_cpu_rdata <= 8'hFF;
                        r_state <= S_IDLE;
                    end else if (!i_mem_busy) begin
                        o_mem_cs    <= 1'b1;
                        o_mem_write <= r_we;
                        o_mem_addr  <= MEM_BASE + {8'h00, r_addr};
                        o_mem_wdata <= r_wdata;
                        r_busy_seen <= 1'b0;
                        r_state     <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    // Completion has priority over a coincident timeout.
                    if (!r_we && i_mem_data_ready) begin
                        o_cpu_rdata <= i_mem_rdata;
                        r_state     <= S_IDLE;
                    end else if (r_we && r_busy_seen && !i_mem_busy) begin
                        r_state <= S_IDLE;
                    end else if (w_cnt_last) begin
                        o_timeout <= 1'b1;
                        if (!r_we) o_cpu_rdata <= 8'hFF;
                        r_state <= S_IDLE;
                    end else if (i_mem_busy) begin
                        r_busy_seen <= 1'b1;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_bus_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_bus_bridge
// Description : Directed self-checking bench for cpu_bus_bridge. A second
//               instance with MEM_BASE = 24'h010000 shares all inputs so the
//               base offset can be observed on the same transactions.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_bus_bridge;

    logic        clk;
    logic        rst;
    logic        phi0;
    logic [15:0] addr;
    logic [7:0]  cpu_wdata;
    logic        we;
    logic [7:0]  mem_rdata;
    logic        mem_busy;
    logic        mem_ready;

    logic [7:0]  cpu_rdata;
    logic        mem_cs;
    logic        mem_write;
    logic [23:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [3:0]  border_col;
    logic [3:0]  bg_col;
    logic        timeout;
    logic        overrun;

    logic [7:0]  b_cpu_rdata;
    logic        b_mem_cs;
    logic        b_mem_write;
    logic [23:0] b_mem_addr;
    logic [7:0]  b_mem_wdata;
    logic [3:0]  b_border_col;
    logic [3:0]  b_bg_col;
    logic        b_timeout;
    logic        b_overrun;

    int          total;
    int          bad;
    int          cs_count;
    logic [23:0] last_addr;
    logic [23:0] b_last_addr;
    logic        last_write;
    logic [7:0]  last_wdata;

    cpu_bus_bridge dut (
        .clkSys           (clk),
        .reset            (rst),
        .i_phi0           (phi0),
        .i_addr           (addr),
        .i_cpu_wdata      (cpu_wdata),
        .i_we             (we),
        .o_cpu_rdata      (cpu_rdata),
        .o_mem_cs         (mem_cs),
        .o_mem_write      (mem_write),
        .o_mem_addr       (mem_addr),
        .o_mem_wdata      (mem_wdata),
        .i_mem_rdata      (mem_rdata),
        .i_mem_busy       (mem_busy),
        .i_mem_data_ready (mem_ready),
        .o_border_col     (border_col),
        .o_bg_col         (bg_col),
        .o_timeout        (timeout),
        .o_overrun        (overrun)
    );

    cpu_bus_bridge #(.MEM_BASE(24'h010000)) dut_b (
        .clkSys           (clk),
        .reset            (rst),
        .i_phi0           (phi0),
        .i_addr           (addr),
        .i_cpu_wdata      (cpu_wdata),
        .i_we             (we),
        .o_cpu_rdata      (b_cpu_rdata),
        .o_mem_cs         (b_mem_cs),
        .o_mem_write      (b_mem_write),
        .o_mem_addr       (b_mem_addr),
        .o_mem_wdata      (b_mem_wdata),
        .i_mem_rdata      (mem_rdata),
        .i_mem_busy       (mem_busy),
        .i_mem_data_ready (mem_ready),
        .o_border_col     (b_border_col),
        .o_bg_col         (b_bg_col),
        .o_timeout        (b_timeout),
        .o_overrun        (b_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Records every request strobe cycle, sampled just after the clock edge.
    always @(posedge clk) begin
        #1;
        if (mem_cs) begin
            cs_count    = cs_count + 1;
            last_addr   = mem_addr;
            last_write  = mem_write;
            last_wdata  = mem_wdata;
            b_last_addr = b_mem_addr;
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    // One CPU bus cycle; returns at the negedge right after the capture edge.
    task automatic bus_cycle(input logic [15:0] a, input logic w, input logic [7:0] d);
        tick();
        addr      = a;
        we        = w;
        cpu_wdata = d;
        phi0      = 1'b1;
        tick();
        phi0      = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        total++;
        if (cpu_rdata !== 8'hFF) begin
            bad++; $display("FAIL reset_rdata: got %h want ff", cpu_rdata);
        end
        total++;
        if ({mem_cs, mem_write, mem_addr, mem_wdata} !== 34'd0) begin
            bad++; $display("FAIL reset_mem: got cs=%b wr=%b addr=%h wd=%h want all 0",
                            mem_cs, mem_write, mem_addr, mem_wdata);
        end
        total++;
        if ({border_col, bg_col, timeout, overrun} !== 10'd0) begin
            bad++; $display("FAIL reset_regs: got border=%h bg=%h to=%b ov=%b want all 0",
                            border_col, bg_col, timeout, overrun);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_registers();
        int base;
        base = cs_count;
        bus_cycle(16'hD020, 1'b1, 8'h35);
        total++;
        if (border_col !== 4'h5) begin
            bad++; $display("FAIL d020_write: got %h want 5", border_col);
        end
        bus_cycle(16'hD020, 1'b0, 8'h00);
        total++;
        if (cpu_rdata !== 8'hF5) begin
            bad++; $display("FAIL d020_read: got %h want f5", cpu_rdata);
        end
        bus_cycle(16'hD021, 1'b1, 8'hA7);
        bus_cycle(16'hD021, 1'b0, 8'h00);
        total++;
        if ({bg_col, cpu_rdata} !== 12'h7F7) begin
            bad++; $display("FAIL d021_rw: got bg=%h rdata=%h want bg=7 rdata=f7", bg_col, cpu_rdata);
        end
        bus_cycle(16'hD400, 1'b1, 8'h12);
        bus_cycle(16'hD400, 1'b0, 8'h00);
        total++;
        if ({border_col, bg_col, cpu_rdata} !== 16'h57FF) begin
            bad++; $display("FAIL io_open_bus: got border=%h bg=%h rdata=%h want 5 7 ff",
                            border_col, bg_col, cpu_rdata);
        end
        total++;
        if (cs_count !== base) begin
            bad++; $display("FAIL reg_no_cs: got %0d strobes want 0", cs_count - base);
        end
    endtask

    task automatic test_mem_read();
        int base;
        base     = cs_count;
        mem_busy = 1'b1;
        bus_cycle(16'hC000, 1'b0, 8'h00);
        tick();
        tick();
        tick();
        total++;
        if (cs_count !== base) begin
            bad++; $display("FAIL read_cs_while_busy: got %0d strobes want 0", cs_count - base);
        end
        mem_busy = 1'b0;
        tick();
        total++;
        if (cs_count !== base + 1 || last_addr !== 24'h00C000 || last_write !== 1'b0) begin
            bad++; $display("FAIL read_req: got n=%0d addr=%h wr=%b want n=1 addr=00c000 wr=0",
                            cs_count - base, last_addr, last_write);
        end
        mem_busy = 1'b1;
        tick();
        mem_busy  = 1'b0;
        mem_ready = 1'b1;
        mem_rdata = 8'hA9;
        tick();
        mem_ready = 1'b0;
        total++;
        if (cpu_rdata !== 8'hA9 || cs_count !== base + 1) begin
            bad++; $display("FAIL read_data: got rdata=%h n=%0d want a9 n=1", cpu_rdata, cs_count - base);
        end
    endtask

    task automatic test_mem_write();
        int base;
        base     = cs_count;
        mem_busy = 1'b0;
        bus_cycle(16'hFFFF, 1'b1, 8'h42);
        tick();
        total++;
        if (cs_count !== base + 1 || last_addr !== 24'h00FFFF || last_write !== 1'b1 ||
            last_wdata !== 8'h42) begin
            bad++; $display("FAIL write_req: got n=%0d addr=%h wr=%b wd=%h want n=1 00ffff 1 42",
                            cs_count - base, last_addr, last_write, last_wdata);
        end
        total++;
        if (b_last_addr !== 24'h01FFFF) begin
            bad++; $display("FAIL write_base_offset: got %h want 01ffff", b_last_addr);
        end
        mem_busy = 1'b1;
        tick();
        tick();
        mem_busy = 1'b0;
        tick();
        // Bridge must be IDLE again: a register read is served, no overrun.
        bus_cycle(16'hD021, 1'b0, 8'h00);
        total++;
        if (cpu_rdata !== 8'hF7 || overrun !== 1'b0) begin
            bad++; $display("FAIL write_complete: got rdata=%h ov=%b want f7 0", cpu_rdata, overrun);
        end
    endtask

    task automatic test_timeout();
        int base;
        base      = cs_count;
        mem_busy  = 1'b0;
        mem_ready = 1'b0;
        bus_cycle(16'h1000, 1'b0, 8'h00);
        for (int i = 0; i < 63; i++) tick();
        total++;
        if (timeout !== 1'b0 || cpu_rdata !== 8'hF7) begin
            bad++; $display("FAIL timeout_early: got to=%b rdata=%h want 0 f7", timeout, cpu_rdata);
        end
        tick();
        total++;
        if (timeout !== 1'b1 || cpu_rdata !== 8'hFF || cs_count !== base + 1) begin
            bad++; $display("FAIL timeout_abort: got to=%b rdata=%h n=%0d want 1 ff 1",
                            timeout, cpu_rdata, cs_count - base);
        end
    endtask

    task automatic test_overrun();
        mem_busy = 1'b0;
        bus_cycle(16'h2000, 1'b0, 8'h00);
        tick();
        bus_cycle(16'hD020, 1'b1, 8'h3C);
        total++;
        if (overrun !== 1'b1 || border_col !== 4'h5) begin
            bad++; $display("FAIL overrun_flag: got ov=%b border=%h want 1 5", overrun, border_col);
        end
        mem_ready = 1'b1;
        mem_rdata = 8'h5A;
        tick();
        mem_ready = 1'b0;
        total++;
        if (cpu_rdata !== 8'h5A || timeout !== 1'b1) begin
            bad++; $display("FAIL overrun_complete: got rdata=%h to=%b want 5a 1", cpu_rdata, timeout);
        end
        bus_cycle(16'hD020, 1'b0, 8'h00);
        total++;
        if (cpu_rdata !== 8'hF5) begin
            bad++; $display("FAIL overrun_idle: got %h want f5", cpu_rdata);
        end
    endtask

    task automatic test_reset_mid();
        int base;
        base     = cs_count;
        mem_busy = 1'b0;
        bus_cycle(16'h3000, 1'b0, 8'h00);
        tick();
        rst = 1'b1;
        tick();
        total++;
        if (mem_cs !== 1'b0 || timeout !== 1'b0 || overrun !== 1'b0 || cpu_rdata !== 8'hFF ||
            cs_count !== base + 1) begin
            bad++; $display("FAIL reset_wait: got cs=%b to=%b ov=%b rdata=%h n=%0d want 0 0 0 ff 1",
                            mem_cs, timeout, overrun, cpu_rdata, cs_count - base);
        end
        rst       = 1'b0;
        mem_ready = 1'b1;
        mem_rdata = 8'h77;
        tick();
        mem_ready = 1'b0;
        total++;
        if (cpu_rdata !== 8'hFF) begin
            bad++; $display("FAIL reset_dropped: got %h want ff", cpu_rdata);
        end
        // Reset landing on the request edge suppresses the strobe.
        base = cs_count;
        bus_cycle(16'h3001, 1'b0, 8'h00);
        rst = 1'b1;
        tick();
        total++;
        if (mem_cs !== 1'b0 || cs_count !== base) begin
            bad++; $display("FAIL reset_issue: got cs=%b n=%0d want 0 0", mem_cs, cs_count - base);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_rst_vec();
        int base;
        base      = cs_count;
        mem_busy  = 1'b0;
`ifdef GM64_RST_VEC_OVERRIDE_EN
        bus_cycle(16'hFFFC, 1'b0, 8'h00);
        total++;
        if (cpu_rdata !== 8'h00) begin
            bad++; $display("FAIL vec_lo: got %h want 00", cpu_rdata);
        end
        bus_cycle(16'hFFFD, 1'b0, 8'h00);
        total++;
        if (cpu_rdata !== 8'h03 || cs_count !== base) begin
            bad++; $display("FAIL vec_hi: got rdata=%h n=%0d want 03 0", cpu_rdata, cs_count - base);
        end
`else
        bus_cycle(16'hFFFC, 1'b0, 8'h00);
        tick();
        mem_ready = 1'b1;
        mem_rdata = 8'h5C;
        tick();
        mem_ready = 1'b0;
        total++;
        if (cpu_rdata !== 8'h5C || cs_count !== base + 1 || last_addr !== 24'h00FFFC) begin
            bad++; $display("FAIL vec_lo_mem: got rdata=%h n=%0d addr=%h want 5c 1 00fffc",
                            cpu_rdata, cs_count - base, last_addr);
        end
        bus_cycle(16'hFFFD, 1'b0, 8'h00);
        tick();
        mem_ready = 1'b1;
        mem_rdata = 8'hC3;
        tick();
        mem_ready = 1'b0;
        total++;
        if (cpu_rdata !== 8'hC3 || cs_count !== base + 2 || last_addr !== 24'h00FFFD) begin
            bad++; $display("FAIL vec_hi_mem: got rdata=%h n=%0d addr=%h want c3 2 00fffd",
                            cpu_rdata, cs_count - base, last_addr);
        end
`endif
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        cs_count    = 0;
        last_addr   = 24'h0;
        b_last_addr = 24'h0;
        last_write  = 1'b0;
        last_wdata  = 8'h00;
        rst         = 1'b1;
        phi0        = 1'b0;
        addr        = 16'h0000;
        cpu_wdata   = 8'h00;
        we          = 1'b0;
        mem_rdata   = 8'h00;
        mem_busy    = 1'b0;
        mem_ready   = 1'b0;

        test_reset();
        test_registers();
        test_mem_read();
        test_mem_write();
        test_timeout();
        test_overrun();
        test_reset_mid();
        test_rst_vec();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
